text_console_ctrl: RTL and testbench

- Character-cell text console that owns the 40x30 screen memory consumed by vgadisplaydriver.
- Accepts a stream of glyph/command tokens from the MIPS memory-mapped I/O path over a valid/ready handshake.
- Maintains the cursor, performs newline, backspace, clear and hardware scroll.
- Presents a combinational read port (screen_addr -> character_code) to the display driver.

---
 rtl/text_console_ctrl.sv | 275 +++++++++++++++++++++++++++
 tb/tb_text_console_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : text_console_ctrl
// Purpose  : Character-cell text console. Owns the 40x30 screen memory read
//            by the VGA display driver and executes a stream of glyph and
//            command tokens (PUT, NEWLINE, BACKSPACE, CLEAR). It keeps the
//            cursor and performs screen clear and hardware scroll.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1   system clock
//   reset          in   1   synchronous, active-high reset
//   in_valid       in   1   token present
//   in_ready       out  1   token can be accepted this cycle (state IDLE)
//   in_cmd         in   2   00 PUT, 01 NEWLINE, 10 BACKSPACE, 11 CLEAR
//   in_code        in   4   glyph code for PUT, ignored otherwise
//   screen_addr    in   11  display read address = row*40+col
//   character_code out  4   combinational read data for screen_addr
//   cursor_col     out  6   cursor column 0..39
//   cursor_row     out  5   cursor row 0..29
//   busy           out  1   high while clearing or scrolling
// ----------------------------------------------------------------------------
// Optional feature macro: TEXT_CONSOLE_CURSOR_BLINK_EN
//   When defined, a blinking CURSOR_CODE glyph is overlaid on the display
//   read port at the cursor cell while idle. RAM contents are not touched.
// ============================================================================
module text_console_ctrl #(
  parameter int         COLS         = 40,
  parameter int         ROWS         = 30,
  parameter logic [3:0] BLANK_CODE   = 4'd0,
  parameter logic [3:0] CURSOR_CODE  = 4'd15,
  parameter int         BLINK_CYCLES = 12500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_cmd,
  input  logic [3:0]  in_code,
  input  logic [10:0] screen_addr,
  output logic [3:0]  character_code,
  output logic [5:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  // Screen geometry as 11-bit address constants.
  localparam logic [10:0] CELLS      = 11'(COLS * ROWS);
  localparam logic [10:0] LAST_CELL  = 11'(COLS * ROWS - 1);
  // Last destination cell of the copy phase (start of the bottom row - 1).
  localparam logic [10:0] COPY_LAST  = 11'(COLS * (ROWS - 1) - 1);
  localparam logic [10:0] ROW_STRIDE = 11'(COLS);
  localparam logic [5:0]  LAST_COL   = 6'(COLS - 1);
  localparam logic [4:0]  LAST_ROW   = 5'(ROWS - 1);

  localparam logic [1:0] CMD_PUT       = 2'b00;
  localparam logic [1:0] CMD_NEWLINE   = 2'b01;
  localparam logic [1:0] CMD_BACKSPACE = 2'b10;
  localparam logic [1:0] CMD_CLEAR     = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_CLEAR       = 2'd1,
    S_SCROLL_COPY = 2'd2,
    S_SCROLL_FILL = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] ptr_q,   ptr_d;
  logic [5:0]  col_q,   col_d;
  logic [4:0]  row_q,   row_d;

  // Screen memory: one synchronous write port, two asynchronous reads.
  logic [3:0]  mem [0:COLS*ROWS-1];

  logic        w_we;
  logic [10:0] w_waddr;
  logic [3:0]  w_wdata;
  logic        w_accept;
  logic [10:0] w_cur_addr;
  logic [3:0]  w_scroll_src;
  logic [3:0]  w_ram_rd;
  logic        w_blink_phase;
  logic        w_overlay;

  // row*40 + col, with row*40 built as row*32 + row*8 so no multiplier is
  // needed. All terms fit in 11 bits for row <= 29.
  function automatic logic [10:0] cell_addr(input logic [4:0] row,
                                            input logic [5:0] col);
    logic [10:0] r;
    r = {6'd0, row};
    return (r << 5) + (r << 3) + {5'd0, col};
  endfunction

  assign w_cur_addr   = cell_addr(row_q, col_q);
  assign w_accept     = in_valid && (state_q == S_IDLE);
  // Source cell one row below the sweep pointer; only meaningful while
  // copying, where ptr never exceeds COPY_LAST.
  assign w_scroll_src = mem[ptr_q + ROW_STRIDE];

  // --------------------------------------------------------------------------
  // Next-state, cursor and write-port control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    col_d   = col_q;
    row_d   = row_q;
    w_we    = 1'b0;
    w_waddr = ptr_q;
    w_wdata = BLANK_CODE;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          case (in_cmd)
            CMD_PUT: begin
              w_we    = 1'b1;
              w_waddr = w_cur_addr;
              w_wdata = in_code;
              if (col_q == LAST_COL) begin
                col_d = 6'd0;
                if (row_q == LAST_ROW) begin
                  state_d = S_SCROLL_COPY;
                  ptr_d   = 11'd0;
                end else begin
                  row_d = row_q + 5'd1;
                end
              end else begin
                col_d = col_q + 6'd1;
              end
            end
            CMD_NEWLINE: begin
              col_d = 6'd0;
              if (row_q == LAST_ROW) begin
                state_d = S_SCROLL_COPY;
                ptr_d   = 11'd0;
              end else begin
                row_d = row_q + 5'd1;
              end
            end
            CMD_BACKSPACE: begin
              // Step back (wrapping to the end of the previous row) and
              // blank the cell landed on. At the origin nothing happens.
              if (col_q != 6'd0) begin
                col_d   = col_q - 6'd1;
                w_we    = 1'b1;
                w_waddr = cell_addr(row_q, col_q - 6'd1);
              end else if (row_q != 5'd0) begin
                row_d   = row_q - 5'd1;
                col_d   = LAST_COL;
                w_we    = 1'b1;
                w_waddr = cell_addr(row_q - 5'd1, LAST_COL);
              end
            end
            CMD_CLEAR: begin
              col_d   = 6'd0;
              row_d   = 5'd0;
              ptr_d   = 11'd0;
              state_d = S_CLEAR;
            end
            default: ;
          endcase
        end
      end

      S_CLEAR: begin
        w_we = 1'b1;
        if (ptr_q == LAST_CELL) begin
          state_d = S_IDLE;
          ptr_d   = 11'd0;
          col_d   = 6'd0;
          row_d   = 5'd0;
        end else begin
          ptr_d = ptr_q + 11'd1;
        end
      end

      S_SCROLL_COPY: begin
        w_we    = 1'b1;
        w_wdata = w_scroll_src;
        if (ptr_q == COPY_LAST) begin
          state_d = S_SCROLL_FILL;
        end
        ptr_d = ptr_q + 11'd1;
      end

      S_SCROLL_FILL: begin
        w_we = 1'b1;
        if (ptr_q == LAST_CELL) begin
          state_d = S_IDLE;
          ptr_d   = 11'd0;
        end else begin
          ptr_d = ptr_q + 11'd1;
        end
      end

      default: begin
        state_d = S_CLEAR;
        ptr_d   = 11'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CLEAR;
      ptr_q   <= 11'd0;
      col_q   <= 6'd0;
      row_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Writes are suppressed on a reset edge so a token presented alongside
  // reset leaves no trace.
  always_ff @(posedge clk) begin
    if (w_we && !reset) begin
      mem[w_waddr] <= w_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Optional cursor blink phase
  // --------------------------------------------------------------------------
`ifdef TEXT_CONSOLE_CURSOR_BLINK_EN
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;

  always_comb begin
    blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign w_blink_phase = blink_phase_q;
`else
  assign w_blink_phase = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Display read port and status outputs
  // --------------------------------------------------------------------------
  assign w_ram_rd  = (screen_addr < CELLS) ? mem[screen_addr] : BLANK_CODE;
  assign w_overlay = w_blink_phase && (state_q == S_IDLE) &&
                     (screen_addr == w_cur_addr);

  assign character_code = w_overlay ? CURSOR_CODE : w_ram_rd;
  assign in_ready       = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign cursor_col     = col_q;
  assign cursor_row     = row_q;

endmodule
`default_nettype wire

// File: tb/tb_text_console_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_console_ctrl
// Purpose  : Self-checking bench for text_console_ctrl. A behavioural screen
//            model predicts cell contents; expected reads are queued and then
//            compared against the display read port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_console_ctrl;

  localparam int TB_BLINK = 4;
  localparam int NCELLS   = 1200;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_cmd;
  logic [3:0]  in_code;
  logic [10:0] screen_addr;
  logic [3:0]  character_code;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  always #5 clk = ~clk;

  text_console_ctrl #(
    .BLINK_CYCLES(TB_BLINK)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_cmd         (in_cmd),
    .in_code        (in_code),
    .screen_addr    (screen_addr),
    .character_code (character_code),
    .cursor_col     (cursor_col),
    .cursor_row     (cursor_row),
    .busy           (busy)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Behavioural screen model
  logic [3:0] model [NCELLS];
  int         mcol = 0;
  int         mrow = 0;
  bit         m_idle = 1'b0;
  int         pend = 0;   // 0 none, 1 scroll pending, 2 clear pending

  // Clock edges since the last reset edge (drives the blink prediction).
  int cyc = 0;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    string       tag;
    logic [10:0] addr;
    logic [3:0]  val;
  } sb_t;
  sb_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] overlay(input int addr, input logic [3:0] v);
    logic [3:0] r;
    r = v;
`ifdef TEXT_CONSOLE_CURSOR_BLINK_EN
    if (m_idle && (addr == mrow * 40 + mcol) && (((cyc / TB_BLINK) % 2) == 1))
      r = 4'd15;
`endif
    return r;
  endfunction

  task automatic expect_cell(input string tag, input int a);
    sb_t e;
    e.tag  = $sformatf("%s[%0d]", tag, a);
    e.addr = 11'(a);
    e.val  = (a < NCELLS) ? model[a] : 4'd0;
    sb.push_back(e);
  endtask

  task automatic expect_screen(input string tag);
    for (int a = 0; a < NCELLS; a++) expect_cell(tag, a);
  endtask

  // Each queued read is presented and sampled on the following falling edge.
  task automatic drain();
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      screen_addr = e.addr;
      @(negedge clk);
      chk(e.tag, 32'(character_code), 32'(overlay(int'(e.addr), e.val)));
    end
  endtask

  task automatic chk_cursor(input string tag, input int c, input int r);
    chk({tag, "_col"}, 32'(cursor_col), 32'(c));
    chk({tag, "_row"}, 32'(cursor_row), 32'(r));
  endtask

  task automatic model_apply(input logic [1:0] cmd, input logic [3:0] code);
    case (cmd)
      2'd0: begin
        model[mrow * 40 + mcol] = code;
        if (mcol == 39) begin
          mcol = 0;
          if (mrow == 29) begin pend = 1; m_idle = 1'b0; end
          else mrow++;
        end else begin
          mcol++;
        end
      end
      2'd1: begin
        mcol = 0;
        if (mrow == 29) begin pend = 1; m_idle = 1'b0; end
        else mrow++;
      end
      2'd2: begin
        if (mcol > 0) begin
          mcol--;
          model[mrow * 40 + mcol] = 4'd0;
        end else if (mrow > 0) begin
          mrow--;
          mcol = 39;
          model[mrow * 40 + mcol] = 4'd0;
        end
      end
      default: begin
        mcol = 0; mrow = 0; pend = 2; m_idle = 1'b0;
      end
    endcase
  endtask

  task automatic send(input string tag, input logic [1:0] cmd,
                      input logic [3:0] code);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_cmd   = cmd;
    in_code  = code;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_apply(cmd, code);
  endtask

  // Counts clock edges until in_ready returns, then applies the pending
  // model operation.
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_cycles"}, 32'(n), 32'd1200);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    if (pend == 1) begin
      for (int i = 0; i < 1160; i++) model[i] = model[i + 40];
      for (int i = 1160; i < NCELLS; i++) model[i] = 4'd0;
    end else if (pend == 2) begin
      for (int i = 0; i < NCELLS; i++) model[i] = 4'd0;
    end
    pend   = 0;
    m_idle = 1'b1;
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_cmd      = 2'd0;
    in_code     = 4'd0;
    screen_addr = 11'd0;
    for (int i = 0; i < NCELLS; i++) model[i] = 4'hx;

    // ---- Reset: 1200-cycle clear, blank screen, cursor at origin ----
    @(posedge clk);
    #1;
    reset = 1'b0;
    pend  = 2;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ready", 32'(in_ready), 32'd0);
    wait_done("rst");
    chk_cursor("rst_cur", 0, 0);
    expect_screen("rst_cell");
    drain();

    // ---- PUT burst, back-to-back, visible one cycle after each accept ----
    send("put5", 2'd0, 4'd5); expect_cell("burst", 0); drain();
    send("put6", 2'd0, 4'd6); expect_cell("burst", 1); drain();
    send("put7", 2'd0, 4'd7); expect_cell("burst", 2); drain();
    chk_cursor("burst_cur", 3, 0);
    chk("burst_ready", 32'(in_ready), 32'd1);

    // ---- Preload row 1 with 3s, march cursor to (39,29), PUT 9 ----
    send("nl1", 2'd1, 4'd0);
    for (int i = 0; i < 40; i++) send("row1", 2'd0, 4'd3);
    for (int i = 0; i < 27; i++) send("nl", 2'd1, 4'd0);
    for (int i = 0; i < 39; i++) send("row29", 2'd0, 4'((i % 7) + 1));
    chk_cursor("pre_wrap", 39, 29);
    send("wrap", 2'd0, 4'd9);
    expect_cell("pre_scroll", 1199);
    drain();
    chk("scroll_busy", 32'(busy), 32'd1);
    chk_cursor("wrap_cur", 0, 29);
    wait_done("scroll");
    chk_cursor("scroll_cur", 0, 29);
    expect_screen("scroll_cell");
    drain();

    // ---- CLEAR command, then backspace edges ----
    send("clr", 2'd3, 4'd0);
    wait_done("clrcmd");
    chk_cursor("clr_cur", 0, 0);
    for (int i = 0; i < 40; i++) send("row0", 2'd0, 4'd2);
    chk_cursor("bs_pre", 0, 1);
    send("bs_wrap", 2'd2, 4'd0);
    chk_cursor("bs_wrap_cur", 39, 0);
    expect_cell("bs_wrap", 39);
    expect_cell("bs_wrap", 38);
    drain();
    for (int i = 0; i < 39; i++) send("bs", 2'd2, 4'd0);
    chk_cursor("bs_home", 0, 0);
    send("bs_origin", 2'd2, 4'd0);
    chk_cursor("bs_origin_cur", 0, 0);
    expect_screen("bs_origin");
    drain();

    // ---- Reset 500 cycles into a scroll copy ----
    for (int i = 0; i < 5; i++) send("ms_put", 2'd0, 4'd4);
    for (int i = 0; i < 29; i++) send("ms_nl", 2'd1, 4'd0);
    send("ms_scroll", 2'd1, 4'd0);
    repeat (500) @(posedge clk);
    #1;
    chk("ms_busy_mid", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    pend  = 2;
    mcol  = 0;
    mrow  = 0;
    chk("ms_rst_busy", 32'(busy), 32'd1);
    chk("ms_rst_ready", 32'(in_ready), 32'd0);
    wait_done("midscroll");
    chk_cursor("ms_cur", 0, 0);
    expect_screen("ms_cell");
    drain();

    // ---- Cursor cell read over time (blink overlay when enabled) ----
    screen_addr = 11'd0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("blink_%0d", i), 32'(character_code),
          32'(overlay(0, model[0])));
    end

    // ---- Out-of-range display addresses read blank ----
    expect_cell("oor", 1200);
    expect_cell("oor", 2047);
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
